// File: rtl/riscv_corereorderbuffer.sv
// In-order-commit reorder buffer for the long-latency RISCV core.
// Decode allocates at the tail. Two writeback channels clear the pending bits
// of slots in any order. Entries retire from the head in program order, one
// per cycle. Two combinational source queries report the youngest in-flight
// writer of rs1/rs2.
// Optional feature: define ROB_FLUSH_EN to add rob_flush (squash all entries).
module riscv_corereorderbuffer #(
    parameter int DEPTH     = 8,
    parameter int SLOT_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef ROB_FLUSH_EN
    input  logic                 rob_flush,
`endif
    input  logic                 rob_alloc_val,
    output logic                 rob_alloc_rdy,
    input  logic                 rob_alloc_wen,
    input  logic [4:0]           rob_alloc_waddr,
    output logic [SLOT_BITS-1:0] rob_alloc_slot,
    input  logic                 rob_fill_val0,
    input  logic [SLOT_BITS-1:0] rob_fill_slot0,
    input  logic                 rob_fill_val1,
    input  logic [SLOT_BITS-1:0] rob_fill_slot1,
    output logic                 rob_commit_val,
    output logic                 rob_commit_wen,
    output logic [4:0]           rob_commit_waddr,
    output logic [SLOT_BITS-1:0] rob_commit_slot,
    input  logic [4:0]           rob_src0_addr,
    output logic                 rob_src0_hit,
    output logic [SLOT_BITS-1:0] rob_src0_slot,
    output logic                 rob_src0_pending,
    input  logic [4:0]           rob_src1_addr,
    output logic                 rob_src1_hit,
    output logic [SLOT_BITS-1:0] rob_src1_slot,
    output logic                 rob_src1_pending,
    output logic [SLOT_BITS:0]   rob_count
);

    logic [SLOT_BITS:0]        head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0]          valid_q, valid_d, pending_q, pending_d, wen_q, wen_d;
    logic [DEPTH-1:0][4:0]     waddr_q, waddr_d;

    logic                      flush_w;
    logic                      empty, full, alloc_fire;
    logic [SLOT_BITS-1:0]      head_idx, tail_idx;
    logic [SLOT_BITS:0]        count;

`ifdef ROB_FLUSH_EN
    assign flush_w = rob_flush;
`else
    assign flush_w = 1'b0;
`endif

    assign head_idx   = head_q[SLOT_BITS-1:0];
    assign tail_idx   = tail_q[SLOT_BITS-1:0];
    assign count      = tail_q - head_q;
    assign empty      = (head_q == tail_q);
    assign full       = (head_idx == tail_idx) && (head_q[SLOT_BITS] != tail_q[SLOT_BITS]);

    // Ready looks only at registered state: a retiring head does not free a slot this cycle.
    assign rob_alloc_rdy  = !full;
    assign rob_alloc_slot = tail_idx;
    assign alloc_fire     = rob_alloc_val && !full && !flush_w;

    assign rob_commit_val   = !empty && valid_q[head_idx] && !pending_q[head_idx] && !flush_w;
    assign rob_commit_wen   = rob_commit_val && wen_q[head_idx] && (waddr_q[head_idx] != 5'd0);
    assign rob_commit_waddr = waddr_q[head_idx];
    assign rob_commit_slot  = head_idx;
    assign rob_count        = count;

    // Walk slots oldest-to-youngest from head so the last match is the youngest writer.
    function automatic logic [SLOT_BITS+1:0] src_lookup(input logic [4:0] addr);
        logic                 h;
        logic                 p;
        logic [SLOT_BITS-1:0] s;
        logic [SLOT_BITS-1:0] idx;
        h = 1'b0;
        p = 1'b0;
        s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_idx + SLOT_BITS'(i);
            if (((SLOT_BITS+1)'(i) < count) && valid_q[idx] && wen_q[idx] &&
                (waddr_q[idx] == addr) && (addr != 5'd0)) begin
                h = 1'b1;
                p = pending_q[idx];
                s = idx;
            end
        end
        return {h, p, s};
    endfunction

    // Source queries see registered state only.
    always_comb begin
        {rob_src0_hit, rob_src0_pending, rob_src0_slot} = src_lookup(rob_src0_addr);
        {rob_src1_hit, rob_src1_pending, rob_src1_slot} = src_lookup(rob_src1_addr);
    end

    // Next-state: flush squashes everything; otherwise fill, commit and allocate together.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        valid_d   = valid_q;
        pending_d = pending_q;
        wen_d     = wen_q;
        waddr_d   = waddr_q;
        if (flush_w) begin
            valid_d   = '0;
            pending_d = '0;
            tail_d    = head_q;
        end else begin
            // Fills to empty slots or to the slot being allocated are dropped.
            if (rob_fill_val0 && valid_q[rob_fill_slot0] &&
                !(alloc_fire && rob_fill_slot0 == tail_idx))
                pending_d[rob_fill_slot0] = 1'b0;
            if (rob_fill_val1 && valid_q[rob_fill_slot1] &&
                !(alloc_fire && rob_fill_slot1 == tail_idx))
                pending_d[rob_fill_slot1] = 1'b0;
            if (rob_commit_val) begin
                valid_d[head_idx] = 1'b0;
                head_d            = head_q + 1'b1;
            end
            if (alloc_fire) begin
                valid_d[tail_idx]   = 1'b1;
                pending_d[tail_idx] = 1'b1;
                wen_d[tail_idx]     = rob_alloc_wen;
                waddr_d[tail_idx]   = rob_alloc_waddr;
                tail_d              = tail_q + 1'b1;
            end
        end
    end

    // State registers; reset discards every in-flight entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            valid_q   <= '0;
            pending_q <= '0;
            wen_q     <= '0;
            waddr_q   <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
        end
    end

endmodule

// File: tb/tb_riscv_corereorderbuffer.sv
// Self-checking bench for riscv_corereorderbuffer: directed scenarios with
// literal expectations followed by randomized traffic, all checked each cycle
// against a program-order queue model.
module tb_riscv_corereorderbuffer;

    localparam int DEPTH = 8;
    localparam int SB    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          rob_flush;
    logic          rob_alloc_val, rob_alloc_rdy, rob_alloc_wen;
    logic [4:0]    rob_alloc_waddr;
    logic [SB-1:0] rob_alloc_slot;
    logic          rob_fill_val0, rob_fill_val1;
    logic [SB-1:0] rob_fill_slot0, rob_fill_slot1;
    logic          rob_commit_val, rob_commit_wen;
    logic [4:0]    rob_commit_waddr;
    logic [SB-1:0] rob_commit_slot;
    logic [4:0]    rob_src0_addr, rob_src1_addr;
    logic          rob_src0_hit, rob_src0_pending, rob_src1_hit, rob_src1_pending;
    logic [SB-1:0] rob_src0_slot, rob_src1_slot;
    logic [SB:0]   rob_count;

    riscv_corereorderbuffer #(.DEPTH(DEPTH), .SLOT_BITS(SB)) dut (
        .clk(clk), .reset(reset),
`ifdef ROB_FLUSH_EN
        .rob_flush(rob_flush),
`endif
        .rob_alloc_val(rob_alloc_val), .rob_alloc_rdy(rob_alloc_rdy),
        .rob_alloc_wen(rob_alloc_wen), .rob_alloc_waddr(rob_alloc_waddr),
        .rob_alloc_slot(rob_alloc_slot),
        .rob_fill_val0(rob_fill_val0), .rob_fill_slot0(rob_fill_slot0),
        .rob_fill_val1(rob_fill_val1), .rob_fill_slot1(rob_fill_slot1),
        .rob_commit_val(rob_commit_val), .rob_commit_wen(rob_commit_wen),
        .rob_commit_waddr(rob_commit_waddr), .rob_commit_slot(rob_commit_slot),
        .rob_src0_addr(rob_src0_addr), .rob_src0_hit(rob_src0_hit),
        .rob_src0_slot(rob_src0_slot), .rob_src0_pending(rob_src0_pending),
        .rob_src1_addr(rob_src1_addr), .rob_src1_hit(rob_src1_hit),
        .rob_src1_slot(rob_src1_slot), .rob_src1_pending(rob_src1_pending),
        .rob_count(rob_count)
    );

    always #5 clk = ~clk;

    // Model: in-flight instructions in program order, plus the head slot number.
    typedef struct {
        int       slot;
        bit       wen;
        bit [4:0] waddr;
        bit       pend;
    } ent_t;

    ent_t mq[$];
    int   mhead = 0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Youngest queue entry writing addr; returns its position or -1.
    function automatic int youngest(input bit [4:0] addr);
        int r;
        r = -1;
        if (addr != 0)
            for (int i = 0; i < mq.size(); i++)
                if (mq[i].wen && mq[i].waddr == addr) r = i;
        return r;
    endfunction

    function automatic bit model_cval();
        return (mq.size() > 0) && !mq[0].pend && !rob_flush;
    endfunction

    task automatic compare();
        int  sz;
        bit  cv;
        int  y;
        sz = mq.size();
        cv = model_cval();
        chk("alloc_rdy", rob_alloc_rdy, (sz < DEPTH) ? 1 : 0);
        chk("alloc_slot", rob_alloc_slot, (mhead + sz) % DEPTH);
        chk("count", rob_count, sz);
        chk("commit_val", rob_commit_val, cv);
        chk("commit_wen", rob_commit_wen, (cv && mq[0].wen && mq[0].waddr != 0) ? 1 : 0);
        if (cv) begin
            chk("commit_slot", rob_commit_slot, mq[0].slot);
            chk("commit_waddr", rob_commit_waddr, mq[0].waddr);
        end
        y = youngest(rob_src0_addr);
        chk("src0_hit", rob_src0_hit, (y >= 0) ? 1 : 0);
        if (y >= 0) begin
            chk("src0_slot", rob_src0_slot, mq[y].slot);
            chk("src0_pending", rob_src0_pending, mq[y].pend);
        end
        y = youngest(rob_src1_addr);
        chk("src1_hit", rob_src1_hit, (y >= 0) ? 1 : 0);
        if (y >= 0) begin
            chk("src1_slot", rob_src1_slot, mq[y].slot);
            chk("src1_pending", rob_src1_pending, mq[y].pend);
        end
    endtask

    task automatic fill_model(input int s);
        ent_t t;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].slot == s) begin
                t = mq[i];
                t.pend = 1'b0;
                mq[i] = t;
            end
    endtask

    task automatic model_update();
        bit   cv;
        int   sz;
        ent_t e;
        sz = mq.size();
        cv = model_cval();
        if (reset) begin
            mq.delete();
            mhead = 0;
        end else if (rob_flush) begin
            mq.delete();
        end else begin
            if (rob_fill_val0) fill_model(rob_fill_slot0);
            if (rob_fill_val1) fill_model(rob_fill_slot1);
            if (cv) begin
                void'(mq.pop_front());
                mhead = (mhead + 1) % DEPTH;
            end
            if (rob_alloc_val && sz < DEPTH) begin
                e.slot  = (mhead + mq.size()) % DEPTH;
                e.wen   = rob_alloc_wen;
                e.waddr = rob_alloc_waddr;
                e.pend  = 1'b1;
                mq.push_back(e);
            end
        end
    endtask

    // One clock: check outputs mid-cycle, advance the model, move past the edge.
    task automatic step();
        @(negedge clk);
        if (!reset) compare();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rob_alloc_val = 0; rob_alloc_wen = 0; rob_alloc_waddr = 0;
        rob_fill_val0 = 0; rob_fill_slot0 = 0;
        rob_fill_val1 = 0; rob_fill_slot1 = 0;
        rob_flush = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic alloc(input bit w, input bit [4:0] a);
        rob_alloc_val = 1; rob_alloc_wen = w; rob_alloc_waddr = a;
        step();
        rob_alloc_val = 0;
    endtask

    task automatic fill(input int ch, input int s);
        if (ch == 0) begin rob_fill_val0 = 1; rob_fill_slot0 = SB'(s); end
        else         begin rob_fill_val1 = 1; rob_fill_slot1 = SB'(s); end
        step();
        rob_fill_val0 = 0; rob_fill_val1 = 0;
    endtask

    initial begin
        reset = 1;
        rob_src0_addr = 0; rob_src1_addr = 0;
        do_reset();
        chk("lit_rst_rdy", rob_alloc_rdy, 1);
        chk("lit_rst_slot", rob_alloc_slot, 0);
        chk("lit_rst_cval", rob_commit_val, 0);
        chk("lit_rst_count", rob_count, 0);

        // In-order commit with out-of-order fills.
        alloc(1, 5); alloc(1, 6); alloc(1, 7);
        chk("lit_count3", rob_count, 3);
        chk("lit_cval_unfilled", rob_commit_val, 0);
        fill(1, 2);
        chk("lit_no_ooo_commit", rob_commit_val, 0);
        fill(0, 0);
        chk("lit_commit0_val", rob_commit_val, 1);
        chk("lit_commit0_slot", rob_commit_slot, 0);
        chk("lit_commit0_waddr", rob_commit_waddr, 5);
        step();
        chk("lit_slot2_waits", rob_commit_val, 0);
        fill(0, 1);
        chk("lit_commit1_slot", rob_commit_slot, 1);
        step();
        chk("lit_commit2_val", rob_commit_val, 1);
        chk("lit_commit2_slot", rob_commit_slot, 2);
        step();
        chk("lit_drained", rob_count, 0);

        // Full buffer refuses allocation even while the head retires.
        do_reset();
        for (int i = 0; i < DEPTH; i++) alloc(1, 5'(i + 1));
        chk("lit_full_rdy", rob_alloc_rdy, 0);
        chk("lit_full_count", rob_count, DEPTH);
        fill(0, 0);
        chk("lit_full_cval", rob_commit_val, 1);
        chk("lit_full_rdy2", rob_alloc_rdy, 0);
        alloc(1, 20);
        chk("lit_wrap_rdy", rob_alloc_rdy, 1);
        chk("lit_wrap_slot", rob_alloc_slot, 0);
        chk("lit_wrap_count", rob_count, DEPTH - 1);

        // Youngest-writer query.
        do_reset();
        alloc(1, 1); alloc(1, 2); alloc(1, 3); alloc(1, 9); alloc(1, 4); alloc(1, 9);
        fill(0, 3);
        rob_src0_addr = 9; rob_src1_addr = 0;
        step();
        chk("lit_q_hit", rob_src0_hit, 1);
        chk("lit_q_slot", rob_src0_slot, 5);
        chk("lit_q_pend", rob_src0_pending, 1);
        chk("lit_q_x0", rob_src1_hit, 0);

        // x0 destination never reports a register write.
        do_reset();
        alloc(1, 0);
        fill(0, 0);
        chk("lit_x0_cval", rob_commit_val, 1);
        chk("lit_x0_cwen", rob_commit_wen, 0);
        step();

`ifdef ROB_FLUSH_EN
        // Flush with a same-cycle allocation.
        do_reset();
        alloc(1, 1);
        fill(0, 0);
        step();
        alloc(1, 2); alloc(1, 3); alloc(1, 4); alloc(1, 5);
        chk("lit_fl_count4", rob_count, 4);
        rob_flush = 1; rob_alloc_val = 1; rob_alloc_wen = 1; rob_alloc_waddr = 7;
        step();
        idle();
        chk("lit_fl_count", rob_count, 0);
        chk("lit_fl_cval", rob_commit_val, 0);
        chk("lit_fl_slot", rob_alloc_slot, 1);
`endif

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rob_alloc_val   = ($urandom % 3) != 0;
            rob_alloc_wen   = ($urandom % 4) != 0;
            rob_alloc_waddr = 5'($urandom % 16);
            rob_fill_val0   = ($urandom % 2) != 0;
            rob_fill_slot0  = SB'($urandom % DEPTH);
            rob_fill_val1   = ($urandom % 3) == 0;
            rob_fill_slot1  = (($urandom % 4) == 0) ? rob_fill_slot0 : SB'($urandom % DEPTH);
            rob_src0_addr   = 5'($urandom % 16);
            rob_src1_addr   = 5'($urandom % 16);
`ifdef ROB_FLUSH_EN
            rob_flush       = ($urandom % 40) == 0;
`endif
            reset           = ($urandom % 500) == 0;
            step();
        end
        reset = 0;
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
